bin2bcd_seq: RTL

- Sequential binary-to-BCD converter. Sits directly downstream of the pipelined divider and consumes its 26-bit quotient.
- Uses the shift-and-add-3 (double-dabble) method, one bit per clock, to produce packed BCD digits for the display/seven-segment stage.
- Uses a start/busy/done handshake because the divider provides no valid strobe. The controller pulses start once the divider pipeline latency (M-N cycles) has elapsed.

---
 rtl/bin2bcd_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: optional leading-zero blanking in the bcd output is built when BIN2BCD_BLANK_EN is defined.
// Purpose: sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Latency: start accepted at one edge, busy for W cycles, then a one-cycle done pulse with bcd updated.
// Backpressure: none; start is ignored while shifting and is honoured in IDLE or on the done cycle.
module bin2bcd_seq #(
    parameter int W = 26,
    parameter int D = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   bin,
    output logic [4*D-1:0] bcd,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_bin;
    logic [4*D-1:0]  r_scr;
    logic [4*D-1:0]  r_bcd;
    logic            r_busy;
    logic            r_done;

    logic [4*D-1:0]   w_adj;
    logic [4*D+W-1:0] w_shifted;
    logic [4*D-1:0]   w_next_scr;
    logic [4*D-1:0]   w_bcd_out;

    // Add-3 is per nibble with no carry into the neighbour digit.
    always_comb begin
        w_adj = r_scr;
        for (int i = 0; i < D; i++) begin
            if (r_scr[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_shifted  = {w_adj, r_bin} << 1;
    assign w_next_scr = w_shifted[4*D+W-1:W];

`ifdef BIN2BCD_BLANK_EN
    // Leading zeros become the seven-segment blank code; digit 0 always shows.
    function automatic logic [4*D-1:0] f_blank(input logic [4*D-1:0] v);
        logic lead;
        f_blank = v;
        lead    = 1'b1;
        for (int i = D - 1; i >= 1; i--) begin
            if (v[4*i +: 4] != 4'd0) begin
                lead = 1'b0;
            end
            if (lead) begin
                f_blank[4*i +: 4] = 4'hF;
            end
        end
    endfunction

    assign w_bcd_out = f_blank(w_next_scr);
`else
    assign w_bcd_out = w_next_scr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bin   <= '0;
            r_scr   <= '0;
            r_bcd   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_bin   <= bin;
                        r_scr   <= '0;
                        r_cnt   <= CNT_INIT;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_scr <= w_next_scr;
                    r_bin <= w_shifted[W-1:0];
                    r_cnt <= r_cnt - CNT_ONE;
                    // Last shift: publish the result on the same edge that enters DONE.
                    if (r_cnt == CNT_ONE) begin
                        r_bcd   <= w_bcd_out;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_bin   <= bin;
                        r_scr   <= '0;
                        r_cnt   <= CNT_INIT;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bcd  = r_bcd;
    assign busy = r_busy;
    assign done = r_done;

endmodule
